// File: rtl/s3_execute_stage.sv
// s3_execute_stage
//   Execute stage plus the S3 pipeline register. Takes the registered S2
//   operands and controls, forwards the stage's own S3 result back onto
//   operand A / RD2 on a back-to-back RAW hazard, selects operand B,
//   evaluates the ALU, and registers the result and write-back controls.
//   Also keeps a sticky signed-overflow flag and a retired-write counter.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   S2_RD1, S2_RD2       operand read data (DW bits)
//   S2_IMM               16-bit immediate, sign-extended when selected
//   S2_DataSource        0: B = RD2 (forwarded), 1: B = sext(IMM)
//   S2_ALUOP             ALU opcode
//   S2_WS, S2_WE         destination register and write enable
//   S2_RS1, S2_RS2       source register indices used for forwarding
//   S3_Hold              freeze every S3 register this cycle
//   S3_ALUOut, S3_WS,
//   S3_WE, S3_Zero       registered result, destination, enable, zero flag
//   S3_Ovf               sticky signed overflow (cleared only by rst)
//   S3_WrCount           count of retired writes, wraps silently
module s3_execute_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    S2_RD1,
  input  logic [DW-1:0]    S2_RD2,
  input  logic [15:0]      S2_IMM,
  input  logic             S2_DataSource,
  input  logic [2:0]       S2_ALUOP,
  input  logic [4:0]       S2_WS,
  input  logic             S2_WE,
  input  logic [4:0]       S2_RS1,
  input  logic [4:0]       S2_RS2,
  input  logic             S3_Hold,
  output logic [DW-1:0]    S3_ALUOut,
  output logic [4:0]       S3_WS,
  output logic             S3_WE,
  output logic             S3_Zero,
  output logic             S3_Ovf,
  output logic [CNT_W-1:0] S3_WrCount
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  function automatic logic signed [DW-1:0] alu_f(
    input logic [2:0]           op,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b
  );
    logic signed [DW-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r[0] = (a < b);
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = $signed($unsigned(a) >> b[4:0]);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Signed overflow of ADD/SUB: operands (B inverted for SUB) share a sign
  // that the result does not.
  function automatic logic ovf_f(
    input logic [2:0]           op,
    input logic signed [DW-1:0] a,
    input logic signed [DW-1:0] b,
    input logic signed [DW-1:0] r
  );
    logic sa, sb, sr;
    sa = a[DW-1];
    sb = b[DW-1];
    sr = r[DW-1];
    case (op)
      OP_ADD:  return (sa == sb)  && (sr != sa);
      OP_SUB:  return (sa == !sb) && (sr != sa);
      default: return 1'b0;
    endcase
  endfunction

  logic signed [DW-1:0]    alu_out_p1;
  logic [4:0]              ws_p1;
  logic                    we_p1;
  logic                    zero_p1;
  logic                    ovf_p1;
  logic [CNT_W-1:0]        cnt_p1;

  logic                    fwd_a_p0, fwd_b_p0;
  logic signed [DW-1:0]    a_p0, rd2_p0, b_p0, res_p0;
  logic                    ovf_p0;

  // ---- stage p0: forwarding, operand select, ALU ----
  // Forwarding sources are the S3 registers themselves, so a held S3 keeps
  // feeding its value back. Register 0 is never forwarded.
  assign fwd_a_p0 = we_p1 && (ws_p1 != 5'd0) && (ws_p1 == S2_RS1);
  assign fwd_b_p0 = we_p1 && (ws_p1 != 5'd0) && (ws_p1 == S2_RS2);
  assign a_p0     = fwd_a_p0 ? alu_out_p1 : $signed(S2_RD1);
  assign rd2_p0   = fwd_b_p0 ? alu_out_p1 : $signed(S2_RD2);
  assign b_p0     = S2_DataSource ? $signed({{(DW-16){S2_IMM[15]}}, S2_IMM}) : rd2_p0;
  assign res_p0   = alu_f(S2_ALUOP, a_p0, b_p0);
  assign ovf_p0   = ovf_f(S2_ALUOP, a_p0, b_p0, res_p0);

  // ---- stage p1: S3 register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_p1 <= '0;
      ws_p1      <= '0;
      we_p1      <= 1'b0;
      zero_p1    <= 1'b0;
      ovf_p1     <= 1'b0;
      cnt_p1     <= '0;
    end else if (!S3_Hold) begin
      alu_out_p1 <= res_p0;
      ws_p1      <= S2_WS;
      we_p1      <= S2_WE;
      zero_p1    <= (res_p0 == '0);
      ovf_p1     <= ovf_p1 | (ovf_p0 & S2_WE);
      if (S2_WE) cnt_p1 <= cnt_p1 + CNT_W'(1);
    end
  end

  assign S3_ALUOut  = alu_out_p1;
  assign S3_WS      = ws_p1;
  assign S3_WE      = we_p1;
  assign S3_Zero    = zero_p1;
  assign S3_Ovf     = ovf_p1;
  assign S3_WrCount = cnt_p1;

endmodule

// File: tb/tb_s3_execute_stage.sv
// Directed bench for s3_execute_stage: each step drives S2 inputs, pushes
// the expected S3 state to a scoreboard queue, and after the next rising
// edge pops and compares every S3 output.
module tb_s3_execute_stage;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  ws;
    logic        we;
    logic        zero;
    logic        ovf;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] S2_RD1 = '0, S2_RD2 = '0;
  logic [15:0] S2_IMM = '0;
  logic        S2_DataSource = 1'b0;
  logic [2:0]  S2_ALUOP = '0;
  logic [4:0]  S2_WS = '0, S2_RS1 = '0, S2_RS2 = '0;
  logic        S2_WE = 1'b0;
  logic        S3_Hold = 1'b0;
  logic [31:0] S3_ALUOut;
  logic [4:0]  S3_WS;
  logic        S3_WE, S3_Zero, S3_Ovf;
  logic [15:0] S3_WrCount;

  exp_t sb[$];
  int   nvec = 0;
  int   nerr = 0;

  s3_execute_stage #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .S2_RD1(S2_RD1), .S2_RD2(S2_RD2), .S2_IMM(S2_IMM),
    .S2_DataSource(S2_DataSource), .S2_ALUOP(S2_ALUOP),
    .S2_WS(S2_WS), .S2_WE(S2_WE), .S2_RS1(S2_RS1), .S2_RS2(S2_RS2),
    .S3_Hold(S3_Hold),
    .S3_ALUOut(S3_ALUOut), .S3_WS(S3_WS), .S3_WE(S3_WE),
    .S3_Zero(S3_Zero), .S3_Ovf(S3_Ovf), .S3_WrCount(S3_WrCount)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [15:0] imm, input logic ds,
                       input logic [2:0] op, input logic [4:0] ws,
                       input logic we, input logic [4:0] rs1,
                       input logic [4:0] rs2);
    S2_RD1 = rd1; S2_RD2 = rd2; S2_IMM = imm; S2_DataSource = ds;
    S2_ALUOP = op; S2_WS = ws; S2_WE = we; S2_RS1 = rs1; S2_RS2 = rs2;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Push the expected post-edge state, clock once, pop and compare.
  task automatic step(input string tag, input logic [31:0] alu,
                      input logic [4:0] ws, input logic we,
                      input logic zero, input logic ovf,
                      input logic [15:0] cnt);
    exp_t e;
    e.alu = alu; e.ws = ws; e.we = we; e.zero = zero; e.ovf = ovf; e.cnt = cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".alu"},  S3_ALUOut,         e.alu);
      cmp({tag, ".ws"},   {27'd0, S3_WS},    {27'd0, e.ws});
      cmp({tag, ".we"},   {31'd0, S3_WE},    {31'd0, e.we});
      cmp({tag, ".zero"}, {31'd0, S3_Zero},  {31'd0, e.zero});
      cmp({tag, ".ovf"},  {31'd0, S3_Ovf},   {31'd0, e.ovf});
      cmp({tag, ".cnt"},  {16'd0, S3_WrCount}, {16'd0, e.cnt});
    end
  endtask

  initial begin
    logic [31:0] basic_exp [8];
    basic_exp = '{32'd12, 32'd2, 32'd5, 32'd7, 32'd2, 32'd0, 32'd224, 32'd0};

    // Reset with random inputs, then reset together with hold
    #2;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom, $urandom, 16'($urandom), 1'($urandom), 3'($urandom),
            5'($urandom), 1'b1, 5'($urandom), 5'($urandom));
      step("reset", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    end
    S3_Hold = 1'b1;
    step("reset_hold", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0; S3_Hold = 1'b0;

    // Every opcode on 7 and 5
    for (int op = 0; op < 8; op++) begin
      drive(32'd7, 32'd5, 16'd0, 1'b0, 3'(op), 5'd3, 1'b1, 5'd1, 5'd2);
      step($sformatf("alu_op%0d", op), basic_exp[op], 5'd3, 1'b1,
           basic_exp[op] == 32'd0, 1'b0, 16'(op + 1));
    end

    // Reset wins over hold on non-zero state
    rst = 1'b1; S3_Hold = 1'b1;
    step("rst_over_hold", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0; S3_Hold = 1'b0;

    // Immediate operand, RD2 ignored
    drive(32'h10, 32'h12345678, 16'hFFFF, 1'b1, 3'b000, 5'd5, 1'b1, 5'd1, 5'd2);
    step("imm_neg1", 32'h0000000F, 5'd5, 1'b1, 1'b0, 1'b0, 16'd1);
    drive(32'h10, 32'h12345678, 16'hFFF0, 1'b1, 3'b000, 5'd5, 1'b1, 5'd1, 5'd2);
    step("imm_zero", 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 16'd2);

    // Forward S3 result onto A
    drive(32'd4, 32'd5, 16'd0, 1'b0, 3'b000, 5'd4, 1'b1, 5'd1, 5'd2);
    step("fwd_prod", 32'd9, 5'd4, 1'b1, 1'b0, 1'b0, 16'd3);
    drive(32'hDEAD, 32'd1, 16'd0, 1'b0, 3'b000, 5'd6, 1'b1, 5'd4, 5'd2);
    step("fwd_a", 32'd10, 5'd6, 1'b1, 1'b0, 1'b0, 16'd4);

    // Register 0 is never forwarded
    drive(32'd4, 32'd5, 16'd0, 1'b0, 3'b000, 5'd0, 1'b1, 5'd1, 5'd2);
    step("r0_prod", 32'd9, 5'd0, 1'b1, 1'b0, 1'b0, 16'd5);
    drive(32'hDEAD, 32'd1, 16'd0, 1'b0, 3'b000, 5'd6, 1'b1, 5'd0, 5'd0);
    step("r0_nofwd", 32'hDEAE, 5'd6, 1'b1, 1'b0, 1'b0, 16'd6);

    // Both operands forwarded: 6 - 6
    drive(32'd3, 32'd3, 16'd0, 1'b0, 3'b000, 5'd7, 1'b1, 5'd1, 5'd2);
    step("both_prod", 32'd6, 5'd7, 1'b1, 1'b0, 1'b0, 16'd7);
    drive(32'd100, 32'd200, 16'd0, 1'b0, 3'b001, 5'd8, 1'b1, 5'd7, 5'd7);
    step("both_fwd", 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 16'd8);

    // Hold for three cycles with changing inputs
    S3_Hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h7FFFFFFF + 32'(i), 32'd1, 16'd0, 1'b0, 3'b000,
            5'(20 + i), 1'b1, 5'd1, 5'd2);
      step($sformatf("hold%0d", i), 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 16'd8);
    end
    // Release: A forwarded from held S3 (0) + 9
    S3_Hold = 1'b0;
    drive(32'd5, 32'd9, 16'd0, 1'b0, 3'b000, 5'd9, 1'b1, 5'd8, 5'd2);
    step("release", 32'd9, 5'd9, 1'b1, 1'b0, 1'b0, 16'd9);

    // Sticky overflow
    drive(32'h7FFFFFFF, 32'd1, 16'd0, 1'b0, 3'b000, 5'd10, 1'b1, 5'd1, 5'd2);
    step("ovf_add", 32'h80000000, 5'd10, 1'b1, 1'b0, 1'b1, 16'd10);
    drive(32'hF, 32'h3, 16'd0, 1'b0, 3'b010, 5'd11, 1'b1, 5'd1, 5'd2);
    step("ovf_sticky", 32'h3, 5'd11, 1'b1, 1'b0, 1'b1, 16'd11);
    drive(32'hF0, 32'h0F, 16'd0, 1'b0, 3'b100, 5'd12, 1'b0, 5'd1, 5'd2);
    step("we0_nocount", 32'hFF, 5'd12, 1'b0, 1'b0, 1'b1, 16'd11);

    // Fresh reset: overflow with WE=0 leaves the flag clear
    rst = 1'b1;
    step("rst2", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    drive(32'h7FFFFFFF, 32'd1, 16'd0, 1'b0, 3'b000, 5'd10, 1'b0, 5'd1, 5'd2);
    step("ovf_we0", 32'h80000000, 5'd10, 1'b0, 1'b0, 1'b0, 16'd0);
    drive(32'h80000000, 32'd1, 16'd0, 1'b0, 3'b001, 5'd13, 1'b1, 5'd1, 5'd2);
    step("ovf_sub", 32'h7FFFFFFF, 5'd13, 1'b1, 1'b0, 1'b1, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/s3_execute_stage.md
Name: s3_execute_stage

Overview:
- Execute stage plus the S3 pipeline register. Sits directly downstream of the S2 register.
- Consumes the registered S2 operands, immediate, ALU opcode and write-back controls. Selects operand B, resolves back-to-back RAW hazards by forwarding its own S3 result, and computes the ALU result.
- Registers the result and write-back controls into S3 outputs that drive the register-file write port.
- Also maintains a sticky signed-overflow flag and a count of retired writes.

Parameters:
- DW, 32, datapath width. RD1, RD2 and the ALU result are DW bits.
- CNT_W, 16, width of the retired-write counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- S2_RD1  in  32  operand A read data
- S2_RD2  in  32  operand B read data
- S2_IMM  in  16  immediate
- S2_DataSource  in  1  0: B = S2_RD2; 1: B = sign-extended S2_IMM
- S2_ALUOP  in  3  ALU opcode
- S2_WS  in  5  destination register
- S2_WE  in  1  write enable
- S2_RS1  in  5  source register index of RD1 (for forwarding)
- S2_RS2  in  5  source register index of RD2 (for forwarding)
- S3_Hold  in  1  1: freeze all S3 registers this cycle
- S3_ALUOut  out  32  registered ALU result
- S3_WS  out  5  registered destination
- S3_WE  out  1  registered write enable
- S3_Zero  out  1  registered (result == 0)
- S3_Ovf  out  1  sticky signed overflow
- S3_WrCount  out  CNT_W  number of retired writes (S3_WE captured as 1)

Behaviour:
- Reset: when rst=1 at a posedge, all outputs become 0 (S3_ALUOut, S3_WS, S3_WE, S3_Zero, S3_Ovf, S3_WrCount). rst has priority over S3_Hold.
- Forwarding, combinational:
  - A = S3_ALUOut when S3_WE=1, S3_WS!=0 and S3_WS==S2_RS1; otherwise A = S2_RD1.
  - Forwarded RD2 = S3_ALUOut under the same condition against S2_RS2; otherwise S2_RD2.
  - Register 0 is never forwarded.
- Operand B = forwarded RD2 when S2_DataSource=0. When S2_DataSource=1, B = {16{S2_IMM[15]}, S2_IMM}; the forwarded RD2 is ignored.
- ALUOP encoding:
  - 000 ADD: A+B, mod 2^32
  - 001 SUB: A−B, mod 2^32
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: signed compare, result 1 or 0
  - 110 SLL: A << B[4:0]
  - 111 SRL: logical, A >> B[4:0]
- Overflow: set only for ADD/SUB, when both operands have equal sign (for SUB: A and ~B) and the result sign differs.
- Latency: 1 cycle. On a posedge with rst=0 and S3_Hold=0:
  - S3_ALUOut, S3_WS, S3_WE and S3_Zero capture the current-cycle values.
  - S3_Ovf <= S3_Ovf | (ovf & S2_WE).
  - S3_WrCount increments by 1 when S2_WE=1.
- Counter wraps at 2^CNT_W−1 → 0 with no flag.
- Hold: with S3_Hold=1, every S3 register keeps its value. Forwarding remains active from the held S3 values. Sticky overflow and the counter do not change.
- S2_WE=0: the result is still computed and registered. No count increment and no overflow update.
- S2_WS=0 with S2_WE=1: registered and counted as normal. Forwarding ignores it.
- Forwarding with S2_RS1 == S2_RS2 == S3_WS: both paths forward.
- The sticky overflow flag clears only on rst.

Test Plan:
- Reset: assert rst for 2 cycles with random S2 inputs → all outputs 0. Then S3_Hold=1 together with rst=1 → outputs still 0.
- Basic ALU: RD1=7, RD2=5, DataSource=0, WE=1, WS=3, one cycle per opcode 000–111 → S3_ALUOut = 12, 2, 5, 7, 2, 0, 224, 0. S3_WrCount=8 at the end.
- Immediate: RD1=0x10, IMM=0xFFFF, DataSource=1, ADD → 0x0000000F, S3_Zero=0. Then IMM=0xFFF0, ADD → 0, S3_Zero=1.
- Forwarding:
  - Cycle n: ADD writing WS=4, result 9.
  - Cycle n+1: RS1=4, RD1=0xDEAD, RD2=1, ADD → S3_ALUOut=10.
  - Repeat with WS=0 → no forwarding, result 0xDEAE.
- Overflow sticky: RD1=0x7FFFFFFF, RD2=1, ADD, WE=1 → S3_ALUOut=0x80000000, S3_Ovf=1. Following non-overflowing ops keep S3_Ovf=1. The same overflow case with WE=0 on a fresh reset leaves S3_Ovf=0.
- Hold: hold S3_Hold=1 for 3 cycles with changing inputs → S3 outputs and S3_WrCount unchanged. Release → the next posedge captures the current inputs.
